// File: rtl/trace_dump.sv
// Streams the circular trace RAM back out one byte at a time, oldest sample first,
// over a valid/ready byte interface. Pulses done/clr_cap_done after the final byte.
module trace_dump #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] trace_end,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              tx_ready,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic              done,
    output logic              clr_cap_done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BYTE = '1;

    state_t            state;
    logic [ADDR_W-1:0] count;

    // ram_addr doubles as the read pointer: it only advances on acceptance and
    // is otherwise held, so it always names the byte currently in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            ram_en       <= 1'b0;
            ram_addr     <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            clr_cap_done <= 1'b0;
        end else begin
            ram_en       <= 1'b0;
            done         <= 1'b0;
            clr_cap_done <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            ram_addr <= trace_end + 1'b1;
                            count    <= '0;
                            ram_en   <= 1'b1;
                            busy     <= 1'b1;
                            state    <= READ;
                        end
                    end
                    READ: begin
                        state <= WAIT;
                    end
                    // RAM output is valid here; capture it for the sink
                    WAIT: begin
                        tx_data  <= ram_rdata;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                    SEND: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            count    <= count + 1'b1;
                            if (count == LAST_BYTE) begin
                                done         <= 1'b1;
                                clr_cap_done <= 1'b1;
                                state        <= FIN;
                            end else begin
                                ram_addr <= ram_addr + 1'b1;
                                ram_en   <= 1'b1;
                                state    <= READ;
                            end
                        end
                    end
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
